// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the debug-module port arbiter.
// The default window constants are also used by the soc_top address decode.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    localparam logic HOST_D = 1'b0;
    localparam logic HOST_F = 1'b1;

    localparam logic [31:0] DM_BASE_DEFAULT = 32'hCD00_0000;
    localparam logic [31:0] DM_MASK_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin picker.
// On a tie, the requester that was not granted last wins.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = HOST_D;
        if (req[HOST_D] && req[HOST_F]) begin
            gnt_id = ~last;
        end else if (req[HOST_F]) begin
            gnt_id = HOST_F;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Serialises the data-bus (D) and debug-fetch (F) requesters onto the single dm_top
// slave port: one access at a time, fixed latency, out-of-window accesses answered locally.
//
// state | meaning
// IDLE  | no access in progress; arbitrate and latch the winner's command
// ISSUE | slave_req_o high for one cycle with the latched command
// RESP  | ready to the winner, read data passed through from slave_rdata_i
// ERR   | address outside the window; ready with zero data, dm_top untouched
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] DM_BASE = XLEN'(DM_BASE_DEFAULT),
    parameter logic [XLEN-1:0] DM_MASK = XLEN'(DM_MASK_DEFAULT)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [XLEN-1:0]     d_addr_i,
    input  logic [XLEN/8-1:0]   d_be_i,
    input  logic [XLEN-1:0]     d_wdata_i,
    output logic                d_ready_o,
    output logic [XLEN-1:0]     d_rdata_o,
    output logic                d_err_o,
    input  logic                f_req_i,
    input  logic [XLEN-1:0]     f_addr_i,
    output logic                f_ready_o,
    output logic [XLEN-1:0]     f_rdata_o,
    output logic                slave_req_o,
    output logic                slave_we_o,
    output logic [XLEN-1:0]     slave_addr_o,
    output logic [XLEN/8-1:0]   slave_be_o,
    output logic [XLEN-1:0]     slave_wdata_o,
    input  logic [XLEN-1:0]     slave_rdata_i,
    output logic                busy_o
);

    localparam int BW = XLEN / 8;

    arb_state_t      state_q, state_d;
    logic            cmd_host_q;
    logic            cmd_we_q;
    logic [XLEN-1:0] cmd_addr_q;
    logic [BW-1:0]   cmd_be_q;
    logic [XLEN-1:0] cmd_wdata_q;
    logic            last_grant_q;

    logic            gnt_valid;
    logic            gnt_id;
    logic [XLEN-1:0] win_addr;
    logic            win_in_range;

    rr_arb2 u_rr_arb2 (
        .req       ({f_req_i, d_req_i}),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign win_addr     = (gnt_id == HOST_F) ? f_addr_i : d_addr_i;
    assign win_in_range = ((win_addr & DM_MASK) == DM_BASE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = win_in_range ? ISSUE : ERR;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command and grant history only move on a grant; mid-access inputs are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_host_q   <= HOST_D;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_be_q     <= '0;
            cmd_wdata_q  <= '0;
            last_grant_q <= HOST_D;
        end else if (state_q == IDLE && gnt_valid) begin
            cmd_host_q   <= gnt_id;
            cmd_addr_q   <= win_addr;
            last_grant_q <= gnt_id;
            if (gnt_id == HOST_F) begin
                cmd_we_q    <= 1'b0;
                cmd_be_q    <= '1;
                cmd_wdata_q <= '0;
            end else begin
                cmd_we_q    <= d_we_i;
                cmd_be_q    <= d_be_i;
                cmd_wdata_q <= d_wdata_i;
            end
        end
    end

    always_comb begin
        slave_req_o   = 1'b0;
        slave_we_o    = 1'b0;
        slave_addr_o  = '0;
        slave_be_o    = '0;
        slave_wdata_o = '0;
        d_ready_o     = 1'b0;
        d_rdata_o     = '0;
        d_err_o       = 1'b0;
        f_ready_o     = 1'b0;
        f_rdata_o     = '0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                slave_req_o   = 1'b1;
                slave_we_o    = cmd_we_q;
                slave_addr_o  = cmd_addr_q;
                slave_be_o    = cmd_be_q;
                slave_wdata_o = cmd_wdata_q;
            end
            RESP: begin
                if (cmd_host_q == HOST_F) begin
                    f_ready_o = 1'b1;
                    f_rdata_o = slave_rdata_i;
                end else begin
                    d_ready_o = 1'b1;
                    d_rdata_o = slave_rdata_i;
                end
            end
            ERR: begin
                // F gets zero data, which decodes as an illegal instruction.
                if (cmd_host_q == HOST_F) begin
                    f_ready_o = 1'b1;
                end else begin
                    d_ready_o = 1'b1;
                    d_err_o   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: expected responses are queued as stimulus
// is driven and compared against observed ready pulses and slave accesses.
module tb_dm_port_arbiter;

    typedef struct {
        logic        host;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        host;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_ready, d_err;
    logic [31:0] d_rdata;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic m_last;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    acc_t acc_q[$];

    dm_port_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .d_req_i       (d_req),
        .d_we_i        (d_we),
        .d_addr_i      (d_addr),
        .d_be_i        (d_be),
        .d_wdata_i     (d_wdata),
        .d_ready_o     (d_ready),
        .d_rdata_o     (d_rdata),
        .d_err_o       (d_err),
        .f_req_i       (f_req),
        .f_addr_i      (f_addr),
        .f_ready_o     (f_ready),
        .f_rdata_o     (f_rdata),
        .slave_req_o   (s_req),
        .slave_we_o    (s_we),
        .slave_addr_o  (s_addr),
        .slave_be_o    (s_be),
        .slave_wdata_o (s_wdata),
        .slave_rdata_i (s_rdata),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dm_top stand-in: 0xCD00_0100 reads back as 0x1234_5678.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'hDF34_5778;
    endfunction

    function automatic void push_exp(input logic host, input logic [31:0] addr, input logic we,
                                     input logic [3:0] be, input logic [31:0] wdata, input int base);
        exp_t e;
        e.host  = host;
        e.addr  = addr;
        e.we    = (host == 1'b1) ? 1'b0 : we;
        e.be    = (host == 1'b1) ? 4'hF : be;
        e.wdata = (host == 1'b1) ? 32'h0 : wdata;
        e.err   = ((addr & 32'hFFFF_0000) != 32'hCD00_0000);
        e.rdata = e.err ? 32'h0 : rd_fn(addr);
        e.cyc   = base + (e.err ? 1 : 2);
        exp_q.push_back(e);
    endfunction

    // Monitor and slave model, sampled on the falling edge.
    initial begin
        bit prev_req;
        acc_t a;
        rsp_t r;
        prev_req = 1'b0;
        s_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (s_req) begin
                a.cyc = cyc; a.addr = s_addr; a.we = s_we; a.be = s_be; a.wdata = s_wdata;
                acc_q.push_back(a);
                s_rdata = rd_fn(s_addr);
            end
            if (d_ready) begin
                r.cyc = cyc; r.host = 1'b0; r.rdata = d_rdata; r.err = d_err;
                rsp_q.push_back(r);
            end
            if (f_ready) begin
                r.cyc = cyc; r.host = 1'b1; r.rdata = f_rdata; r.err = 1'b0;
                rsp_q.push_back(r);
            end
            checks++;
            if ((d_ready && f_ready) || (s_req && prev_req) ||
                (!d_ready && (d_rdata !== 32'h0 || d_err !== 1'b0)) ||
                (!f_ready && f_rdata !== 32'h0)) begin
                errors++;
                $display("FAIL invariant @cyc %0d: d_ready %0b f_ready %0b slave_req %0b prev %0b d_rdata %h d_err %0b f_rdata %h, required single ready, 1-cycle slave_req, idle outputs 0",
                         cyc, d_ready, f_ready, s_req, prev_req, d_rdata, d_err, f_rdata);
            end
            prev_req = s_req;
        end
    end

    task automatic wait_rsp(input int n, input string name);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (rsp_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: responses %0d, required %0d", name, rsp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; d_req = 0; d_we = 0; d_addr = 0; d_be = 4'hF; d_wdata = 0;
        f_req = 0; f_addr = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_req, s_we, s_addr, s_be, s_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_slave: req %0b we %0b addr %h be %h wdata %h, required all 0", s_req, s_we, s_addr, s_be, s_wdata);
        end
        checks++;
        if ({d_ready, d_rdata, d_err, f_ready, f_rdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_host: d_ready %0b d_rdata %h d_err %0b f_ready %0b f_rdata %h busy %0b, required all 0",
                     d_ready, d_rdata, d_err, f_ready, f_rdata, busy);
        end
        rst_n  = 1'b1;
        m_last = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_single_read();
        exp_t e; rsp_t r; acc_t a;
        d_req = 1; d_we = 0; d_addr = 32'hCD00_0100; d_be = 4'hF; d_wdata = 0;
        push_exp(1'b0, d_addr, 1'b0, 4'hF, 32'h0, cyc);
        m_last = 1'b0;
        wait_rsp(1, "single_read");
        d_req = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_q.size() == 0) begin errors++; $display("FAIL single_read_rsp: none, required host %0d", e.host); end
            else begin
                r = rsp_q.pop_front();
                if (r.host !== e.host || r.cyc != e.cyc || r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL single_read_rsp: host %0d cyc %0d rdata %h err %0b, required host %0d cyc %0d rdata %h err %0b",
                             r.host, r.cyc, r.rdata, r.err, e.host, e.cyc, e.rdata, e.err);
                end
            end
            checks++;
            if (acc_q.size() == 0) begin errors++; $display("FAIL single_read_acc: none, required addr %h", e.addr); end
            else begin
                a = acc_q.pop_front();
                if (a.cyc != e.cyc - 1 || a.addr !== e.addr || a.we !== e.we || a.be !== e.be || a.wdata !== e.wdata) begin
                    errors++;
                    $display("FAIL single_read_acc: cyc %0d addr %h we %0b be %h wdata %h, required cyc %0d addr %h we %0b be %h wdata %h",
                             a.cyc, a.addr, a.we, a.be, a.wdata, e.cyc - 1, e.addr, e.we, e.be, e.wdata);
                end
            end
        end
        repeat (2) @(negedge clk); #1;
    endtask

    // Generic drain used by the remaining scenarios, written once per task to keep each self-contained.
    task automatic test_tie_alternation();
        exp_t e; rsp_t r; acc_t a; int t0; logic w;
        t0 = cyc;
        d_req = 1; d_we = 0; d_addr = 32'hCD00_0104; d_be = 4'hF; d_wdata = 0;
        f_req = 1; f_addr = 32'hCD00_0800;
        for (int i = 0; i < 4; i++) begin
            w = ~m_last;
            push_exp(w, w ? f_addr : d_addr, 1'b0, 4'hF, 32'h0, t0 + 3 * i);
            m_last = w;
        end
        wait_rsp(4, "tie_alternation");
        d_req = 0; f_req = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_q.size() == 0) begin errors++; $display("FAIL tie_rsp: none, required host %0d", e.host); end
            else begin
                r = rsp_q.pop_front();
                if (r.host !== e.host || r.cyc != e.cyc || r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL tie_rsp: host %0d cyc %0d rdata %h err %0b, required host %0d cyc %0d rdata %h err %0b",
                             r.host, r.cyc, r.rdata, r.err, e.host, e.cyc, e.rdata, e.err);
                end
            end
            checks++;
            if (acc_q.size() == 0) begin errors++; $display("FAIL tie_acc: none, required addr %h", e.addr); end
            else begin
                a = acc_q.pop_front();
                if (a.cyc != e.cyc - 1 || a.addr !== e.addr || a.we !== e.we || a.be !== e.be) begin
                    errors++;
                    $display("FAIL tie_acc: cyc %0d addr %h we %0b be %h, required cyc %0d addr %h we %0b be %h",
                             a.cyc, a.addr, a.we, a.be, e.cyc - 1, e.addr, e.we, e.be);
                end
            end
        end
        repeat (2) @(negedge clk); #1;
        checks++;
        if (rsp_q.size() != 0 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL tie_extra: responses %0d accesses %0d, required 0 0", rsp_q.size(), acc_q.size());
        end
        rsp_q.delete(); acc_q.delete();
    endtask

    task automatic test_err_write();
        exp_t e; rsp_t r; int t0;
        t0 = cyc;
        d_req = 1; d_we = 1; d_addr = 32'hC000_0000; d_be = 4'hF; d_wdata = 32'h0000_0005;
        push_exp(1'b0, d_addr, 1'b1, 4'hF, d_wdata, t0);
        m_last = 1'b0;
        wait_rsp(1, "err_write");
        d_req = 0; d_we = 0;
        @(negedge clk); #1;
        t0 = cyc;
        d_req = 1; d_addr = 32'hCD00_0108;
        f_req = 1; f_addr = 32'hCD00_080C;
        push_exp(~m_last, ~m_last ? f_addr : d_addr, 1'b0, 4'hF, 32'h0, t0);
        m_last = ~m_last;
        wait_rsp(2, "err_then_tie");
        d_req = 0; f_req = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_q.size() == 0) begin errors++; $display("FAIL err_rsp: none, required host %0d", e.host); end
            else begin
                r = rsp_q.pop_front();
                if (r.host !== e.host || r.cyc != e.cyc || r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL err_rsp: host %0d cyc %0d rdata %h err %0b, required host %0d cyc %0d rdata %h err %0b",
                             r.host, r.cyc, r.rdata, r.err, e.host, e.cyc, e.rdata, e.err);
                end
            end
        end
        checks++;
        if (acc_q.size() != 1 || acc_q[0].addr !== 32'hCD00_080C) begin
            errors++;
            $display("FAIL err_acc: accesses %0d, required exactly one (the F fetch at cd00080c)", acc_q.size());
        end
        repeat (2) @(negedge clk); #1;
        rsp_q.delete(); acc_q.delete();
    endtask

    task automatic test_late_f();
        exp_t e; rsp_t r; acc_t a; int t0;
        t0 = cyc;
        d_req = 1; d_we = 1; d_addr = 32'hCD00_0380; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        push_exp(1'b0, d_addr, 1'b1, 4'b0011, d_wdata, t0);
        @(negedge clk); #1;
        f_req = 1; f_addr = 32'hCD00_0810;
        push_exp(1'b1, f_addr, 1'b0, 4'hF, 32'h0, t0 + 3);
        m_last = 1'b1;
        wait_rsp(1, "late_f_d");
        d_req = 0; d_we = 0;
        wait_rsp(2, "late_f_f");
        f_req = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_q.size() == 0) begin errors++; $display("FAIL late_f_rsp: none, required host %0d", e.host); end
            else begin
                r = rsp_q.pop_front();
                if (r.host !== e.host || r.cyc != e.cyc || r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL late_f_rsp: host %0d cyc %0d rdata %h err %0b, required host %0d cyc %0d rdata %h err %0b",
                             r.host, r.cyc, r.rdata, r.err, e.host, e.cyc, e.rdata, e.err);
                end
            end
            checks++;
            if (acc_q.size() == 0) begin errors++; $display("FAIL late_f_acc: none, required addr %h", e.addr); end
            else begin
                a = acc_q.pop_front();
                if (a.cyc != e.cyc - 1 || a.addr !== e.addr || a.we !== e.we || a.be !== e.be || a.wdata !== e.wdata) begin
                    errors++;
                    $display("FAIL late_f_acc: cyc %0d addr %h we %0b be %h wdata %h, required cyc %0d addr %h we %0b be %h wdata %h",
                             a.cyc, a.addr, a.we, a.be, a.wdata, e.cyc - 1, e.addr, e.we, e.be, e.wdata);
                end
            end
        end
        repeat (2) @(negedge clk); #1;
    endtask

    task automatic test_reset_issue();
        exp_t e; rsp_t r; acc_t a; int t1;
        d_req = 1; d_we = 0; d_addr = 32'hCD00_0110; d_be = 4'hF; d_wdata = 0;
        @(negedge clk); #1;
        checks++;
        if (s_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_issue_pre: slave_req %0b busy %0b, required 1 1", s_req, busy);
        end
        f_req = 1; f_addr = 32'hCD00_0814;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_req !== 1'b0 || busy !== 1'b0 || d_ready !== 1'b0 || f_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue_async: slave_req %0b busy %0b d_ready %0b f_ready %0b, required 0 0 0 0", s_req, busy, d_ready, f_ready);
        end
        d_req = 0;
        repeat (2) @(negedge clk); #1;
        checks++;
        if (rsp_q.size() != 0 || acc_q.size() != 1 || acc_q[0].addr !== 32'hCD00_0110) begin
            errors++;
            $display("FAIL rst_issue_abort: responses %0d accesses %0d, required 0 responses and only the aborted D access", rsp_q.size(), acc_q.size());
        end
        acc_q.delete();
        rst_n = 1'b1;
        m_last = 1'b0;
        t1 = cyc;
        push_exp(1'b1, f_addr, 1'b0, 4'hF, 32'h0, t1);
        m_last = 1'b1;
        wait_rsp(1, "rst_issue_f");
        f_req = 0;
        e = exp_q.pop_front();
        checks++;
        if (rsp_q.size() == 0) begin errors++; $display("FAIL rst_issue_rsp: none, required host 1"); end
        else begin
            r = rsp_q.pop_front();
            if (r.host !== e.host || r.cyc != e.cyc || r.rdata !== e.rdata) begin
                errors++;
                $display("FAIL rst_issue_rsp: host %0d cyc %0d rdata %h, required host %0d cyc %0d rdata %h",
                         r.host, r.cyc, r.rdata, e.host, e.cyc, e.rdata);
            end
        end
        checks++;
        if (acc_q.size() == 0) begin errors++; $display("FAIL rst_issue_acc: none, required addr %h", e.addr); end
        else begin
            a = acc_q.pop_front();
            if (a.cyc != e.cyc - 1 || a.addr !== e.addr || a.we !== 1'b0 || a.be !== 4'hF) begin
                errors++;
                $display("FAIL rst_issue_acc: cyc %0d addr %h we %0b be %h, required cyc %0d addr %h we 0 be f",
                         a.cyc, a.addr, a.we, a.be, e.cyc - 1, e.addr);
            end
        end
        repeat (2) @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e; rsp_t r; acc_t a; int t0;
        logic [31:0] addrs [3];
        addrs[0] = 32'hCD00_0800; addrs[1] = 32'hCD00_0804; addrs[2] = 32'hCD00_0808;
        t0 = cyc;
        f_req = 1; f_addr = addrs[0];
        for (int i = 0; i < 3; i++) push_exp(1'b1, addrs[i], 1'b0, 4'hF, 32'h0, t0 + 3 * i);
        m_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_rsp(i + 1, "back_to_back");
            if (i < 2) f_addr = addrs[i + 1];
        end
        f_req = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_q.size() == 0) begin errors++; $display("FAIL b2b_rsp: none, required addr %h", e.addr); end
            else begin
                r = rsp_q.pop_front();
                if (r.host !== e.host || r.cyc != e.cyc || r.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL b2b_rsp: host %0d cyc %0d rdata %h, required host %0d cyc %0d rdata %h",
                             r.host, r.cyc, r.rdata, e.host, e.cyc, e.rdata);
                end
            end
            checks++;
            if (acc_q.size() == 0) begin errors++; $display("FAIL b2b_acc: none, required addr %h", e.addr); end
            else begin
                a = acc_q.pop_front();
                if (a.cyc != e.cyc - 1 || a.addr !== e.addr || a.we !== 1'b0 || a.be !== 4'hF) begin
                    errors++;
                    $display("FAIL b2b_acc: cyc %0d addr %h we %0b be %h, required cyc %0d addr %h we 0 be f",
                             a.cyc, a.addr, a.we, a.be, e.cyc - 1, e.addr);
                end
            end
        end
        repeat (3) @(negedge clk); #1;
        checks++;
        if (rsp_q.size() != 0 || acc_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra: responses %0d accesses %0d busy %0b, required 0 0 0", rsp_q.size(), acc_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_alternation();
        test_err_write();
        test_late_f();
        test_reset_issue();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
